// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_4b_cin_cout.sv
// Combinational 4-bit adder with carry-in and carry-out.
module adder_4b_cin_cout (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign sum    = w_full[3:0];
    assign cout   = w_full[4];

endmodule

// File: rtl/adder_serial_ctrl.sv
// Adds two W-bit operands one nibble per cycle, LSB nibble first, through a
// single 4-bit adder; val/rdy handshakes on request and response.
module adder_serial_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [4*NIBBLES-1:0]   resp_sum,
    output logic                   resp_cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;

    logic                w_accept;
    logic                w_resp_hs;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_cout;

    assign w_a_nib = r_a[int'(r_idx) * NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[int'(r_idx) * NIBBLE_W +: NIBBLE_W];

    adder_4b_cin_cout u_adder (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_rdy     = 1'b0;
        resp_val    = 1'b0;
        case (r_state)
            IDLE: begin
                req_rdy = !reset;
                if (req_val) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept  = req_val && req_rdy;
    assign w_resp_hs = resp_val && resp_rdy;

    // Operands need no reset: they are only read in CALC, after a load.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= req_a;
            r_b <= req_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == CALC) begin
            r_sum[int'(r_idx) * NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
            r_carry <= w_nib_cout;
            // Index parks on the last nibble; it wraps on the response handshake.
            if (r_idx != LAST_IDX) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else if (w_resp_hs) begin
            r_idx <= '0;
        end
    end

    assign resp_sum  = r_sum;
    assign resp_cout = r_carry;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Directed bench for adder_serial_ctrl (NIBBLES=4, 16-bit operands).
module tb_adder_serial_ctrl;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_val;
    logic        resp_rdy;
    logic [15:0] resp_sum;
    logic        resp_cout;

    int total = 0;
    int bad   = 0;

    adder_serial_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_a     (req_a),
        .req_b     (req_b),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_sum  (resp_sum),
        .resp_cout (resp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after the acceptance edge; result is due 4 edges later.
    task automatic wait_resp(input string tag, input logic [15:0] exp_sum, input logic exp_cout);
        int cnt;
        cnt = 0;
        while (!resp_val && cnt < 20) begin
            step();
            cnt++;
        end
        chk({tag, "_lat"}, cnt, 4);
        chk({tag, "_sum"}, resp_sum, exp_sum);
        chk({tag, "_cout"}, resp_cout, exp_cout);
    endtask

    task automatic accept(input string tag, input logic [15:0] a, input logic [15:0] b);
        req_val = 1'b1;
        req_a   = a;
        req_b   = b;
        chk({tag, "_rdy"}, req_rdy, 1'b1);
        step();
        req_val = 1'b0;
        req_a   = 16'hDEAD;
        req_b   = 16'hBEEF;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_sum, input logic exp_cout);
        accept(tag, a, b);
        wait_resp(tag, exp_sum, exp_cout);
        step();
        chk({tag, "_hs_val"}, resp_val, 1'b0);
        chk({tag, "_hs_rdy"}, req_rdy, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        req_val  = 1'b0;
        req_a    = 16'h0;
        req_b    = 16'h0;
        resp_rdy = 1'b1;
        step();
        step();
        chk("rst_req_rdy", req_rdy, 1'b0);
        chk("rst_resp_val", resp_val, 1'b0);
        chk("rst_sum", resp_sum, 16'h0000);
        chk("rst_cout", resp_cout, 1'b0);
        reset = 1'b0;
        #1;
        chk("idle_req_rdy", req_rdy, 1'b1);

        run_op("zero", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        run_op("mix", 16'h1234, 16'h4321, 16'h5555, 1'b0);
        run_op("nibcarry", 16'h000F, 16'h0001, 16'h0010, 1'b0);
        run_op("wrapall", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        run_op("msbcarry", 16'h8000, 16'h8000, 16'h0000, 1'b1);

        // Backpressure: hold the response for 3 cycles.
        resp_rdy = 1'b0;
        accept("bp", 16'h7FFF, 16'h0001);
        wait_resp("bp", 16'h8000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_val", resp_val, 1'b1);
            chk("bp_hold_sum", resp_sum, 16'h8000);
            chk("bp_hold_rdy", req_rdy, 1'b0);
        end
        resp_rdy = 1'b1;
        step();
        chk("bp_rel_val", resp_val, 1'b0);
        chk("bp_rel_rdy", req_rdy, 1'b1);

        // req_val stays high with new operands during CALC and DONE.
        resp_rdy = 1'b0;
        req_val  = 1'b1;
        req_a    = 16'h0F0F;
        req_b    = 16'h0101;
        step();
        req_a = 16'hABCD;
        req_b = 16'h1111;
        wait_resp("ign1", 16'h1010, 1'b0);
        step();
        chk("ign_done_rdy", req_rdy, 1'b0);
        chk("ign_done_sum", resp_sum, 16'h1010);
        resp_rdy = 1'b1;
        step();
        chk("ign_idle_rdy", req_rdy, 1'b1);
        chk("ign_idle_val", resp_val, 1'b0);
        step();
        req_val = 1'b0;
        wait_resp("ign2", 16'hBCDE, 1'b0);
        step();
        chk("ign2_hs_rdy", req_rdy, 1'b1);

        // Reset during the second CALC cycle aborts the operation.
        accept("abort", 16'h1234, 16'h1111);
        step();
        reset = 1'b1;
        #1;
        chk("abort_rst_rdy", req_rdy, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("abort_val", resp_val, 1'b0);
        chk("abort_sum", resp_sum, 16'h0000);
        chk("abort_cout", resp_cout, 1'b0);
        chk("abort_rdy", req_rdy, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_quiet_val", resp_val, 1'b0);
        end
        run_op("post", 16'h00FF, 16'h0001, 16'h0100, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
